// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port IDs, port count and the per-output
// allocator state encoding. The port decoder uses the same ID constants.
package noc_pkg;

    localparam int NUM_PORTS     = 5;
    localparam int PORT_ID_WIDTH = 3;

    typedef logic [2:0] port_id_t;

    localparam port_id_t LOCAL = 3'd0;
    localparam port_id_t NORTH = 3'd1;
    localparam port_id_t EAST  = 3'd2;
    localparam port_id_t SOUTH = 3'd3;
    localparam port_id_t WEST  = 3'd4;

    typedef enum logic {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector, one bit per requester
//   ptr_i : highest-priority requester index
//   gnt_o : one-hot grant (all zero when nothing requests)
//   idx_o : index of the granted requester (0 when nothing requests)
module rr_arbiter #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            // Explicit wrap so non-power-of-two N scans exactly N slots.
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (gnt_o == '0 && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = W'(j);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: one round-robin arbiter and IDLE/LOCKED FSM per
// output port. A head flit's input wins an output, then keeps it until its
// tail flit transfers.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid/head/tail/port_req : per-input flit status and requested output
//   out_ready     : per-output downstream accept
//   in_grant      : per-input pop (flit transfers this cycle)
//   out_valid     : per-output valid flit on the crossbar
//   xbar_sel      : per-output selected input index
module switch_allocator
    import noc_pkg::*;
#(
    parameter int NUM_PORTS     = noc_pkg::NUM_PORTS,
    parameter int PORT_ID_WIDTH = noc_pkg::PORT_ID_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_PORTS-1:0]                     in_valid,
    input  logic [NUM_PORTS-1:0]                     in_head,
    input  logic [NUM_PORTS-1:0]                     in_tail,
    input  logic [NUM_PORTS-1:0][PORT_ID_WIDTH-1:0]  in_port_req,
    input  logic [NUM_PORTS-1:0]                     out_ready,
    output logic [NUM_PORTS-1:0]                     in_grant,
    output logic [NUM_PORTS-1:0]                     out_valid,
    output logic [NUM_PORTS-1:0][PORT_ID_WIDTH-1:0]  xbar_sel
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    // gnt_m[o] is the one-hot input granted through output o this cycle.
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt_m;

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        alloc_state_e         state_q;
        logic [PTR_W-1:0]     owner_q;
        logic [PTR_W-1:0]     rr_q;
        logic [PTR_W-1:0]     rr_d;
        logic [NUM_PORTS-1:0] req;
        logic [NUM_PORTS-1:0] win_gnt;
        logic [PTR_W-1:0]     win_idx;
        logic                 locked;
        logic                 own_vld;
        logic                 xfer;

        // Only head flits request; IDs >= NUM_PORTS never match any o.
        always_comb begin
            req = '0;
            for (int i = 0; i < NUM_PORTS; i++)
                req[i] = in_valid[i] & in_head[i] &
                         (in_port_req[i] == PORT_ID_WIDTH'(o));
        end

        rr_arbiter #(.N(NUM_PORTS), .W(PTR_W)) u_arb (
            .req_i (req),
            .ptr_i (rr_q),
            .gnt_o (win_gnt),
            .idx_o (win_idx)
        );

        assign locked  = (state_q == ALLOC_LOCKED);
        assign own_vld = in_valid[owner_q];
        assign xfer    = locked & own_vld & out_ready[o];
        assign rr_d    = (owner_q == PTR_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ALLOC_IDLE;
                owner_q <= '0;
                rr_q    <= '0;
            end else begin
                case (state_q)
                    ALLOC_IDLE: begin
                        // Allocation cycle moves no flit.
                        if (|win_gnt) begin
                            owner_q <= win_idx;
                            state_q <= ALLOC_LOCKED;
                        end
                    end
                    ALLOC_LOCKED: begin
                        // An empty owner buffer keeps the lock; only the tail releases it.
                        if (xfer && in_tail[owner_q]) begin
                            state_q <= ALLOC_IDLE;
                            rr_q    <= rr_d;
                        end
                    end
                    default: state_q <= ALLOC_IDLE;
                endcase
            end
        end

        // owner_q persists through IDLE, so the select holds its last value.
        assign xbar_sel[o]  = PORT_ID_WIDTH'(owner_q);
        assign out_valid[o] = locked & own_vld;
        assign gnt_m[o]     = xfer ? (NUM_PORTS'(1) << owner_q) : '0;
    end

    // An input requests a single output, so at most one row hits per column.
    always_comb begin
        in_grant = '0;
        for (int o = 0; o < NUM_PORTS; o++)
            in_grant = in_grant | gnt_m[o];
    end

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;

    logic            clk;
    logic            rst;
    logic [4:0]      in_valid;
    logic [4:0]      in_head;
    logic [4:0]      in_tail;
    logic [4:0][2:0] in_port_req;
    logic [4:0]      out_ready;
    logic [4:0]      in_grant;
    logic [4:0]      out_valid;
    logic [4:0][2:0] xbar_sel;

    switch_allocator #(.NUM_PORTS(5), .PORT_ID_WIDTH(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_head     (in_head),
        .in_tail     (in_tail),
        .in_port_req (in_port_req),
        .out_ready   (out_ready),
        .in_grant    (in_grant),
        .out_valid   (out_valid),
        .xbar_sel    (xbar_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [4:0] g;
        logic [4:0] ov;
        logic [14:0] xs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Pack five 3-bit IDs, highest port first: ids(p4,p3,p2,p1,p0).
    function automatic logic [14:0] ids(input int p4, p3, p2, p1, p0);
        return {3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    // Drive one cycle of inputs and queue the response expected in that cycle.
    task automatic step(input int id, input logic r,
                        input logic [4:0] v, h, t, input logic [14:0] pr,
                        input logic [4:0] rdy,
                        input logic [4:0] eg, eov, input logic [14:0] exs);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        in_valid    = v;
        in_head     = h;
        in_tail     = t;
        in_port_req = pr;
        out_ready   = rdy;
        e.id = id; e.g = eg; e.ov = eov; e.xs = exs;
        sb.push_back(e);
    endtask

    // Monitor: compare whatever the DUT presents mid-cycle against the queue head.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (in_grant !== e.g || out_valid !== e.ov || xbar_sel !== e.xs) begin
                errors++;
                $display("FAIL cyc%0d: got grant=%b valid=%b sel=%h, want grant=%b valid=%b sel=%h",
                         e.id, in_grant, out_valid, xbar_sel, e.g, e.ov, e.xs);
            end
        end
    end

    initial begin
        logic [14:0] z;
        logic [14:0] pc;
        z = ids(0, 0, 0, 0, 0);
        rst = 1'b1; in_valid = '0; in_head = '0; in_tail = '0;
        in_port_req = '0; out_ready = '1;

        // Reset with random inputs
        for (int k = 1; k <= 2; k++)
            step(k, 1'b1, 5'($urandom), 5'($urandom), 5'($urandom),
                 15'($urandom), 5'($urandom), 5'b0, 5'b0, z);

        // Head at input 2 to EAST: allocate, head, tail
        step(3, 0, 5'b00100, 5'b00100, 5'b00000, ids(0,0,2,0,0), 5'b11111, 5'b00000, 5'b00000, z);
        step(4, 0, 5'b00100, 5'b00100, 5'b00000, ids(0,0,2,0,0), 5'b11111, 5'b00100, 5'b00100, ids(0,0,2,0,0));
        step(5, 0, 5'b00100, 5'b00000, 5'b00100, ids(0,0,2,0,0), 5'b11111, 5'b00100, 5'b00100, ids(0,0,2,0,0));
        step(6, 0, 5'b00000, 5'b00000, 5'b00000, z,               5'b11111, 5'b00000, 5'b00000, ids(0,0,2,0,0));

        // Contention: inputs 0,1,3 single-flit packets to output 4
        pc = ids(0, 4, 0, 4, 4);
        step(7,  0, 5'b01011, 5'b01011, 5'b01011, pc, 5'b11111, 5'b00000, 5'b00000, ids(0,0,2,0,0));
        step(8,  0, 5'b01011, 5'b01011, 5'b01011, pc, 5'b11111, 5'b00001, 5'b10000, ids(0,0,2,0,0));
        step(9,  0, 5'b01011, 5'b01011, 5'b01011, pc, 5'b11111, 5'b00000, 5'b00000, ids(0,0,2,0,0));
        step(10, 0, 5'b01011, 5'b01011, 5'b01011, pc, 5'b11111, 5'b00010, 5'b10000, ids(1,0,2,0,0));
        step(11, 0, 5'b01011, 5'b01011, 5'b01011, pc, 5'b11111, 5'b00000, 5'b00000, ids(1,0,2,0,0));
        step(12, 0, 5'b01011, 5'b01011, 5'b01011, pc, 5'b11111, 5'b01000, 5'b10000, ids(3,0,2,0,0));
        step(13, 0, 5'b01011, 5'b01011, 5'b01011, pc, 5'b11111, 5'b00000, 5'b00000, ids(3,0,2,0,0));
        step(14, 0, 5'b01011, 5'b01011, 5'b01011, pc, 5'b11111, 5'b00001, 5'b10000, ids(0,0,2,0,0));
        step(15, 0, 5'b01011, 5'b01011, 5'b01011, pc, 5'b11111, 5'b00000, 5'b00000, ids(0,0,2,0,0));
        step(16, 0, 5'b01011, 5'b01011, 5'b01011, pc, 5'b11111, 5'b00010, 5'b10000, ids(1,0,2,0,0));
        step(17, 0, 5'b01011, 5'b01011, 5'b01011, pc, 5'b11111, 5'b00000, 5'b00000, ids(1,0,2,0,0));
        step(18, 0, 5'b01011, 5'b01011, 5'b01011, pc, 5'b11111, 5'b01000, 5'b10000, ids(3,0,2,0,0));
        step(19, 0, 5'b00000, 5'b00000, 5'b00000, z,  5'b11111, 5'b00000, 5'b00000, ids(3,0,2,0,0));

        // Wormhole hold: input 1 4-flit packet to output 0, input 3 head waits
        step(20, 0, 5'b01010, 5'b01010, 5'b01000, z, 5'b11111, 5'b00000, 5'b00000, ids(3,0,2,0,0));
        step(21, 0, 5'b01010, 5'b01010, 5'b01000, z, 5'b11111, 5'b00010, 5'b00001, ids(3,0,2,0,1));
        step(22, 0, 5'b01010, 5'b01000, 5'b01000, z, 5'b11111, 5'b00010, 5'b00001, ids(3,0,2,0,1));
        step(23, 0, 5'b01010, 5'b01000, 5'b01000, z, 5'b11111, 5'b00010, 5'b00001, ids(3,0,2,0,1));
        step(24, 0, 5'b01010, 5'b01000, 5'b01010, z, 5'b11111, 5'b00010, 5'b00001, ids(3,0,2,0,1));
        step(25, 0, 5'b01000, 5'b01000, 5'b01000, z, 5'b11111, 5'b00000, 5'b00000, ids(3,0,2,0,1));
        step(26, 0, 5'b01000, 5'b01000, 5'b01000, z, 5'b11111, 5'b01000, 5'b00001, ids(3,0,2,0,3));
        step(27, 0, 5'b00000, 5'b00000, 5'b00000, z, 5'b11111, 5'b00000, 5'b00000, ids(3,0,2,0,3));

        // Backpressure: input 4 to output 1, out_ready[1] low for 5 cycles
        pc = ids(1, 0, 0, 0, 0);
        step(28, 0, 5'b10000, 5'b10000, 5'b00000, pc, 5'b11111, 5'b00000, 5'b00000, ids(3,0,2,0,3));
        step(29, 0, 5'b10000, 5'b10000, 5'b00000, pc, 5'b11101, 5'b00000, 5'b00010, ids(3,0,2,4,3));
        step(30, 0, 5'b00000, 5'b00000, 5'b00000, pc, 5'b11101, 5'b00000, 5'b00000, ids(3,0,2,4,3));
        step(31, 0, 5'b10000, 5'b10000, 5'b00000, pc, 5'b11101, 5'b00000, 5'b00010, ids(3,0,2,4,3));
        step(32, 0, 5'b10000, 5'b10000, 5'b00000, pc, 5'b11101, 5'b00000, 5'b00010, ids(3,0,2,4,3));
        step(33, 0, 5'b10000, 5'b10000, 5'b00000, pc, 5'b11101, 5'b00000, 5'b00010, ids(3,0,2,4,3));
        step(34, 0, 5'b10000, 5'b10000, 5'b00000, pc, 5'b11111, 5'b10000, 5'b00010, ids(3,0,2,4,3));
        step(35, 0, 5'b10000, 5'b00000, 5'b10000, pc, 5'b11111, 5'b10000, 5'b00010, ids(3,0,2,4,3));
        step(36, 0, 5'b00000, 5'b00000, 5'b00000, z,  5'b11111, 5'b00000, 5'b00000, ids(3,0,2,4,3));

        // Parallel: 0->2, 2->4, 4->0 allocated together
        pc = ids(0, 0, 4, 0, 2);
        step(37, 0, 5'b10101, 5'b10101, 5'b10101, pc, 5'b11111, 5'b00000, 5'b00000, ids(3,0,2,4,3));
        step(38, 0, 5'b10101, 5'b10101, 5'b10101, pc, 5'b11111, 5'b10101, 5'b10101, ids(2,0,0,4,4));
        step(39, 0, 5'b00000, 5'b00000, 5'b00000, z,  5'b11111, 5'b00000, 5'b00000, ids(2,0,0,4,4));

        // Out-of-range port IDs never granted
        step(40, 0, 5'b00010, 5'b00010, 5'b00010, ids(0,0,0,7,0), 5'b11111, 5'b00000, 5'b00000, ids(2,0,0,4,4));
        step(41, 0, 5'b00010, 5'b00010, 5'b00010, ids(0,0,0,7,0), 5'b11111, 5'b00000, 5'b00000, ids(2,0,0,4,4));
        step(42, 0, 5'b00010, 5'b00010, 5'b00010, ids(0,0,0,5,0), 5'b11111, 5'b00000, 5'b00000, ids(2,0,0,4,4));

        // Reset while output 4 is locked by input 2 (rr_ptr[4] was 3)
        pc = ids(0, 0, 4, 0, 0);
        step(43, 0, 5'b00100, 5'b00100, 5'b00000, pc, 5'b11111, 5'b00000, 5'b00000, ids(2,0,0,4,4));
        step(44, 0, 5'b00100, 5'b00100, 5'b00000, pc, 5'b11111, 5'b00100, 5'b10000, ids(2,0,0,4,4));
        step(45, 1, 5'b00100, 5'b00000, 5'b00000, pc, 5'b11111, 5'b00100, 5'b10000, ids(2,0,0,4,4));
        pc = ids(0, 4, 4, 4, 4);
        step(46, 0, 5'b01111, 5'b01011, 5'b01011, pc, 5'b11111, 5'b00000, 5'b00000, z);
        step(47, 0, 5'b01111, 5'b01011, 5'b01011, pc, 5'b11111, 5'b00001, 5'b10000, z);
        step(48, 0, 5'b00000, 5'b00000, 5'b00000, z,  5'b11111, 5'b00000, 5'b00000, z);

        // Let the monitor drain, bounded
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-router output-port allocator for wormhole XY routing.
- Each input port presents the output port ID produced by its port decoder, plus head/tail flit markers.
- The block arbitrates each output port round-robin among competing head flits.
- The winning input holds the output until its tail flit transfers.
- It drives crossbar select lines and per-input transfer grants; it sits between the input buffers/port decoders and the 5x5 crossbar.

Parameters:
- NUM_PORTS, 5, number of router ports (input = output count).
- PORT_ID_WIDTH, 3, width of a port ID.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NUM_PORTS  input i holds a flit at its buffer head.
- in_head  input  NUM_PORTS  flit at input i is a head flit.
- in_tail  input  NUM_PORTS  flit at input i is a tail flit; a single-flit packet has head=tail=1.
- in_port_req  input  NUM_PORTS*PORT_ID_WIDTH  requested output ID for input i (slice i).
- out_ready  input  NUM_PORTS  downstream of output o accepts a flit this cycle.
- in_grant  output  NUM_PORTS  flit at input i transfers this cycle; the buffer pops it.
- out_valid  output  NUM_PORTS  output o carries a valid flit this cycle.
- xbar_sel  output  NUM_PORTS*PORT_ID_WIDTH  input index routed to output o (slice o).

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: every output FSM goes to IDLE; owner[o]=0; rr_ptr[o]=0. Next cycle, in_grant=0, out_valid=0, xbar_sel=0.
- Request vector per output o: req[o][i] = in_valid[i] & in_head[i] & (in_port_req[i]==o). A port ID >= NUM_PORTS matches no output, is never granted, and the flit stalls.
- Per-output FSM, states IDLE and LOCKED:
  - IDLE, no request: stay IDLE. Outputs for o are 0; xbar_sel[o] holds its last value.
  - IDLE, any req[o] set: winner = first set i scanning rr_ptr[o], rr_ptr[o]+1, ..., modulo NUM_PORTS. Register owner[o]=winner and go to LOCKED.
  - No flit transfers in the allocation cycle, so allocation latency is 1 cycle.
  - LOCKED: xbar_sel[o]=owner[o]; out_valid[o]=in_valid[owner[o]]; in_grant[owner[o]]=in_valid[owner[o]] & out_ready[o] (combinational).
  - LOCKED, transfer with in_tail[owner] set: next state IDLE and rr_ptr[o]=(owner+1) mod NUM_PORTS. The output can be re-allocated in the following cycle, so a back-to-back packet sees a 1-cycle bubble.
  - LOCKED, in_valid[owner]=0 (buffer empty mid-packet): hold the lock, no grant. Non-head flits never cause re-arbitration.
- Only head flits create requests. A body or tail flit at an input that owns no output is not granted.
- Each input requests exactly one output, so at most one output can own an input and in_grant is one-hot per input. An input owning an output never re-requests, because its head has already transferred.
- Different outputs arbitrate independently in the same cycle. One input may win output A while other inputs win B, C, ...
- A single-flit packet (head=tail=1) is allocated in cycle N, transfers in N+1 if out_ready, and the output returns to IDLE in N+2.
- rr_ptr wraps from NUM_PORTS-1 to 0. The modulo uses width $clog2(NUM_PORTS) with explicit wrap, never power-of-2 truncation.
- Reset during LOCKED drops all locks immediately at the clock edge. A partially sent packet is abandoned; upstream flushing is out of scope.
- out_ready low only stalls the transfer; the lock and owner are retained.

Decomposition:
- Shared package noc_pkg holds:
  - port ID constants LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4;
  - NUM_PORTS;
  - typedef port_id_t logic[2:0].
- The same constants are used by the port decoder.
- Sub-module rr_arbiter (NUM_PORTS-wide request vector, pointer in, one-hot grant and index out) is instantiated once per output inside a generate loop.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> in_grant=0, out_valid=0, xbar_sel=0; after release, a head at input 2 requesting EAST(2) is granted in cycle 2 after it appears.
- Contention: inputs 0, 1, 3 issue single-flit packets to output 4 each cycle, out_ready=1 -> owners in order 0, 1, 3, 0, 1, 3, one grant per 2 cycles.
- Wormhole hold: input 1 sends a 4-flit packet to output 0 while input 3 requests output 0 with a head -> input 3 is not granted until input 1's tail transfers; input 3 is allocated the following cycle.
- Backpressure: locked packet with out_ready=0 for 5 cycles -> in_grant=0 and out_valid follows in_valid; lock is kept and the transfer resumes when out_ready=1.
- Parallel: inputs 0→2, 2→4 and 4→0 at the same time -> all three allocated in the same cycle; xbar_sel[2]=0, xbar_sel[4]=2, xbar_sel[0]=4.
- Invalid ID and mid-reset: in_port_req=7 -> never granted. rst asserted while LOCKED -> next cycle all IDLE, and rr_ptr=0 so input 0 wins the next contention.
